// File: rtl/mm_bram_responder_pkg.sv
// Shared constants and the ownership state type for the matrix-multiplier BRAM responder.
package mm_bram_pkg;

  localparam int MAT_WORDS = 1024;
  localparam int VEC_WORDS = 16;
  localparam int OUT_WORDS = 64;
  localparam int MEM_WORDS = MAT_WORDS + VEC_WORDS + OUT_WORDS;
  localparam int VEC_BASE  = MAT_WORDS;
  localparam int OUT_BASE  = VEC_BASE + VEC_WORDS;
  localparam int ADDR_W    = 11;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_PE   = 1'b1
  } own_state_e;

  // True when a word index lies inside the implemented memory.
  function automatic logic word_in_range(input logic [29:0] word);
    return (word < 30'(MEM_WORDS));
  endfunction

endpackage

// File: rtl/mm_bram_responder_if.sv
// PE BRAM port and host command/response port of the BRAM responder, bundled as one interface.
interface mm_bram_responder_if;
  import mm_bram_pkg::*;

  logic              pe_start;
  logic              pe_done;
  logic [31:0]       bram_addr;
  logic [31:0]       bram_wrdata;
  logic [3:0]        bram_we;
  logic [31:0]       bram_rddata;
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic              host_cmd_write;
  logic [ADDR_W-1:0] host_cmd_addr;
  logic [31:0]       host_cmd_wdata;
  logic              host_rsp_valid;
  logic              host_rsp_ready;
  logic [31:0]       host_rsp_data;
  logic              host_rsp_err;
  logic              pe_active;

  modport master (
    output pe_start, pe_done, bram_addr, bram_wrdata, bram_we,
    output host_cmd_valid, host_cmd_write, host_cmd_addr, host_cmd_wdata, host_rsp_ready,
    input  bram_rddata, host_cmd_ready, host_rsp_valid, host_rsp_data, host_rsp_err, pe_active
  );

  modport slave (
    input  pe_start, pe_done, bram_addr, bram_wrdata, bram_we,
    input  host_cmd_valid, host_cmd_write, host_cmd_addr, host_cmd_wdata, host_rsp_ready,
    output bram_rddata, host_cmd_ready, host_rsp_valid, host_rsp_data, host_rsp_err, pe_active
  );

endinterface

// File: rtl/mm_bram_responder_core.sv
// Single-port, byte-enabled word RAM with registered, read-first output.
module mm_bram_core
  import mm_bram_pkg::*;
(
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  // Contents are never reset so operands survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (addr_i < ADDR_W'(MEM_WORDS)) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= 32'h0000_0000;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mm_bram_responder.sv
// BRAM responder: shares one word RAM between the PE controller and a host port by ownership.
// Optional build macro MM_BRAM_ERRCNT_EN adds pe_err_cnt, a saturating count of out-of-range PE accesses.
module mm_bram_responder
  import mm_bram_pkg::*;
(
  input  logic                aclk,
  input  logic                aresetn,
  mm_bram_responder_if.slave  bus
`ifdef MM_BRAM_ERRCNT_EN
  ,
  output logic [15:0]         pe_err_cnt
`endif
);

  own_state_e        own_q;
  logic              pe_rd_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_fresh_q;
  logic              rsp_rd_q;
  logic [31:0]       rsp_data_q;

  logic              pe_own_s;
  logic              pe_in_range_s;
  logic              host_in_range_s;
  logic              cmd_ready_s;
  logic              cmd_fire_s;
  logic [ADDR_W-1:0] core_addr_s;
  logic [3:0]        core_we_s;
  logic [31:0]       core_wdata_s;
  logic [31:0]       core_rdata_s;
  logic [1:0]        unused_addr_s;

  assign unused_addr_s   = bus.bram_addr[1:0];
  assign pe_own_s        = (own_q == OWN_PE);
  assign pe_in_range_s   = word_in_range(bus.bram_addr[31:2]);
  assign host_in_range_s = (bus.host_cmd_addr < ADDR_W'(MEM_WORDS));
  assign cmd_ready_s     = !pe_own_s && (!rsp_valid_q || bus.host_rsp_ready);
  assign cmd_fire_s      = bus.host_cmd_valid && cmd_ready_s;

  // RAM port follows the current owner; out-of-range writes never reach the array.
  always_comb begin
    core_addr_s  = bus.host_cmd_addr;
    core_we_s    = 4'b0000;
    core_wdata_s = bus.host_cmd_wdata;
    if (pe_own_s) begin
      core_addr_s  = bus.bram_addr[ADDR_W+1:2];
      core_wdata_s = bus.bram_wrdata;
      if (pe_in_range_s) begin
        core_we_s = bus.bram_we;
      end else begin
        core_we_s = 4'b0000;
      end
    end else begin
      if (cmd_fire_s && bus.host_cmd_write && host_in_range_s) begin
        core_we_s = 4'b1111;
      end else begin
        core_we_s = 4'b0000;
      end
    end
  end

  mm_bram_core u_core (
    .clk_i   (aclk),
    .addr_i  (core_addr_s),
    .we_i    (core_we_s),
    .wdata_i (core_wdata_s),
    .rdata_o (core_rdata_s)
  );

  // Ownership FSM; pe_start wins when both pulses coincide.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      own_q   <= OWN_HOST;
      pe_rd_q <= 1'b0;
    end else begin
      pe_rd_q <= pe_own_s && pe_in_range_s;
      case (own_q)
        OWN_HOST: begin
          if (bus.pe_start) begin
            own_q <= OWN_PE;
          end else begin
            own_q <= OWN_HOST;
          end
        end
        OWN_PE: begin
          if (bus.pe_done && !bus.pe_start) begin
            own_q <= OWN_HOST;
          end else begin
            own_q <= OWN_PE;
          end
        end
        default: own_q <= OWN_HOST;
      endcase
    end
  end

  // Response buffer: RAM data is shown live for one cycle, then latched so later accesses cannot disturb it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_fresh_q <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
    end else begin
      if (rsp_fresh_q) begin
        rsp_data_q <= rsp_rd_q ? core_rdata_s : 32'h0000_0000;
      end else begin
        rsp_data_q <= rsp_data_q;
      end
      if (cmd_fire_s) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= !host_in_range_s;
        rsp_fresh_q <= 1'b1;
        rsp_rd_q    <= !bus.host_cmd_write && host_in_range_s;
      end else if (rsp_valid_q && bus.host_rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_fresh_q <= 1'b0;
        rsp_rd_q    <= 1'b0;
      end else begin
        rsp_fresh_q <= 1'b0;
      end
    end
  end

`ifdef MM_BRAM_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of PE cycles that address beyond the memory.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_cnt_q <= 16'h0000;
    end else if (pe_own_s && !pe_in_range_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign pe_err_cnt = err_cnt_q;
`endif

  assign bus.pe_active      = pe_own_s;
  assign bus.host_cmd_ready = cmd_ready_s;
  assign bus.host_rsp_valid = rsp_valid_q;
  assign bus.host_rsp_err   = rsp_err_q;
  assign bus.bram_rddata    = pe_rd_q ? core_rdata_s : 32'h0000_0000;
  assign bus.host_rsp_data  = !rsp_valid_q ? 32'h0000_0000 :
                              rsp_fresh_q  ? (rsp_rd_q ? core_rdata_s : 32'h0000_0000) :
                                             rsp_data_q;

endmodule

// File: tb/tb_mm_bram_responder.sv
// Directed self-checking bench for mm_bram_responder (host preload, PE access, ownership, reset).
module tb_mm_bram_responder;
  import mm_bram_pkg::*;

  logic aclk;
  logic aresetn;
  int   n_total;
  int   n_bad;
  logic [31:0] rd_data;
  logic        rd_err;
`ifdef MM_BRAM_ERRCNT_EN
  logic [15:0] pe_err_cnt;
`endif

  mm_bram_responder_if bus ();

  mm_bram_responder dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
`ifdef MM_BRAM_ERRCNT_EN
    ,
    .pe_err_cnt (pe_err_cnt)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One host command with rsp_ready held high; returns the response seen right after acceptance.
  task automatic host_op(input logic wr, input logic [10:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err);
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_write = wr;
    bus.host_cmd_addr  = addr;
    bus.host_cmd_wdata = wdata;
    #1;
    for (int i = 0; i < 20 && !bus.host_cmd_ready; i++) tick();
    check_eq("host_cmd_ready_wait", {31'd0, bus.host_cmd_ready}, 32'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
    check_eq("host_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    data = bus.host_rsp_data;
    err  = bus.host_rsp_err;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    aresetn = 1'b0;
    bus.pe_start = 1'b0;       bus.pe_done = 1'b0;
    bus.bram_addr = 32'h0;     bus.bram_wrdata = 32'h0;   bus.bram_we = 4'b0000;
    bus.host_cmd_valid = 1'b0; bus.host_cmd_write = 1'b0;
    bus.host_cmd_addr = 11'd0; bus.host_cmd_wdata = 32'h0; bus.host_rsp_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_pe_active", {31'd0, bus.pe_active}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", bus.host_rsp_data, 32'h0);
    check_eq("rst_rsp_err", {31'd0, bus.host_rsp_err}, 32'd0);
    check_eq("rst_rddata", bus.bram_rddata, 32'h0);
    aresetn = 1'b1;
    tick();

    // Host preload and read-back.
    host_op(1'b1, 11'd1024, 32'h0102_0304, rd_data, rd_err);
    check_eq("wr1024_data", rd_data, 32'h0);
    check_eq("wr1024_err", {31'd0, rd_err}, 32'd0);
    host_op(1'b0, 11'd1024, 32'h0, rd_data, rd_err);
    check_eq("rd1024_data", rd_data, 32'h0102_0304);
    check_eq("rd1024_err", {31'd0, rd_err}, 32'd0);
    host_op(1'b1, 11'd1040, 32'h1122_3344, rd_data, rd_err);
    host_op(1'b1, 11'd0, 32'h1234_5678, rd_data, rd_err);

    // PE phase.
    bus.bram_addr = 32'h0000_1000;
    bus.pe_start  = 1'b1;
    tick();
    bus.pe_start = 1'b0;
    check_eq("pe_active_set", {31'd0, bus.pe_active}, 32'd1);
    check_eq("cmd_ready_pe", {31'd0, bus.host_cmd_ready}, 32'd0);
    tick();
    check_eq("pe_rd_1000", bus.bram_rddata, 32'h0102_0304);
    bus.bram_addr   = 32'h0000_1040;
    bus.bram_we     = 4'b0011;
    bus.bram_wrdata = 32'hAABB_CCDD;
    tick();
    check_eq("pe_read_first", bus.bram_rddata, 32'h1122_3344);
    bus.bram_we = 4'b0000;
    tick();
    check_eq("pe_rd_merged", bus.bram_rddata, 32'h1122_CCDD);
    bus.bram_addr   = 32'h0000_2000;
    bus.bram_we     = 4'b1111;
    bus.bram_wrdata = 32'h5555_5555;
    tick();
    check_eq("pe_oor_rd", bus.bram_rddata, 32'h0);
`ifdef MM_BRAM_ERRCNT_EN
    check_eq("pe_err_cnt_1", {16'd0, pe_err_cnt}, 32'd1);
`endif
    bus.bram_addr = 32'h0000_1000;
    bus.bram_we   = 4'b0000;
    bus.pe_done   = 1'b1;
    tick();
    bus.pe_done = 1'b0;
    check_eq("pe_active_clr", {31'd0, bus.pe_active}, 32'd0);
    tick();
    check_eq("rddata_idle", bus.bram_rddata, 32'h0);
    bus.bram_we     = 4'b1111;
    bus.bram_wrdata = 32'hFFFF_FFFF;
    tick();
    bus.bram_we = 4'b0000;
    host_op(1'b0, 11'd1024, 32'h0, rd_data, rd_err);
    check_eq("pe_wr_ignored", rd_data, 32'h0102_0304);
    host_op(1'b0, 11'd1040, 32'h0, rd_data, rd_err);
    check_eq("rd1040_merged", rd_data, 32'h1122_CCDD);
    host_op(1'b0, 11'd0, 32'h0, rd_data, rd_err);
    check_eq("pe_oor_wr_dropped", rd_data, 32'h1234_5678);
    host_op(1'b0, 11'd1200, 32'h0, rd_data, rd_err);
    check_eq("rd1200_data", rd_data, 32'h0);
    check_eq("rd1200_err", {31'd0, rd_err}, 32'd1);
    host_op(1'b1, 11'd1104, 32'hDEAD_BEEF, rd_data, rd_err);
    check_eq("wr1104_err", {31'd0, rd_err}, 32'd1);

    // Back-pressure: response held, then next command accepted on release.
    bus.host_rsp_ready = 1'b0;
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_write = 1'b0;
    bus.host_cmd_addr  = 11'd1024;
    tick();
    bus.host_cmd_addr = 11'd1040;
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
      check_eq("hold_data", bus.host_rsp_data, 32'h0102_0304);
      check_eq("hold_cmd_ready", {31'd0, bus.host_cmd_ready}, 32'd0);
      tick();
    end
    bus.host_rsp_ready = 1'b1;
    #1;
    check_eq("release_cmd_ready", {31'd0, bus.host_cmd_ready}, 32'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
    check_eq("release_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    check_eq("release_rsp_data", bus.host_rsp_data, 32'h1122_CCDD);
    tick();
    check_eq("rsp_consumed", {31'd0, bus.host_rsp_valid}, 32'd0);

    // Simultaneous start and done: start wins.
    bus.pe_start = 1'b1;
    bus.pe_done  = 1'b1;
    tick();
    bus.pe_start = 1'b0;
    bus.pe_done  = 1'b0;
    check_eq("start_wins", {31'd0, bus.pe_active}, 32'd1);
    bus.pe_done = 1'b1;
    tick();
    bus.pe_done = 1'b0;
    check_eq("done_after", {31'd0, bus.pe_active}, 32'd0);

    // Command with pe_start, response pending into PE phase, then reset mid-operation.
    bus.host_rsp_ready = 1'b0;
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_write = 1'b1;
    bus.host_cmd_addr  = 11'd1041;
    bus.host_cmd_wdata = 32'hCAFE_F00D;
    bus.pe_start       = 1'b1;
    #1;
    check_eq("start_cmd_ready", {31'd0, bus.host_cmd_ready}, 32'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
    bus.pe_start       = 1'b0;
    check_eq("start_pe_active", {31'd0, bus.pe_active}, 32'd1);
    check_eq("start_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    bus.bram_addr = 32'h0000_1044;
    tick();
    check_eq("pe_rd_1041", bus.bram_rddata, 32'hCAFE_F00D);
    check_eq("pending_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd1);
    aresetn = 1'b0;
    #1;
    check_eq("arst_pe_active", {31'd0, bus.pe_active}, 32'd0);
    check_eq("arst_rsp_valid", {31'd0, bus.host_rsp_valid}, 32'd0);
    check_eq("arst_rddata", bus.bram_rddata, 32'h0);
`ifdef MM_BRAM_ERRCNT_EN
    check_eq("arst_err_cnt", {16'd0, pe_err_cnt}, 32'd0);
`endif
    tick();
    aresetn = 1'b1;
    bus.host_rsp_ready = 1'b1;
    tick();
    host_op(1'b0, 11'd1041, 32'h0, rd_data, rd_err);
    check_eq("post_rst_1041", rd_data, 32'hCAFE_F00D);
    host_op(1'b0, 11'd1024, 32'h0, rd_data, rd_err);
    check_eq("post_rst_1024", rd_data, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
